// File: rtl/lvds_tx_pll_seq.sv
// lvds_tx_pll_seq: rPLL bring-up sequencer with lock qualification, serdes reset release and retry/fault handling.
module lvds_tx_pll_seq #(
  parameter int NUM_MODES = 4,
  parameter logic [NUM_MODES*18-1:0] MODE_TABLE = '0,
  parameter int RST_HOLD_CYC = 64,
  parameter int LOCK_WAIT_CYC = 65536,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int DS_CYC = 16,
  parameter int MAX_RETRY = 3,
  parameter int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic          clkin,
  input  logic          reset_n,
  input  logic [MW-1:0] mode_sel,
  input  logic          mode_req,
  output logic          mode_ack,
  output logic          mode_err,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic          serdes_rst,
  output logic          pll_ready,
  output logic          fault,
  output logic          relock_evt,
  output logic [RW-1:0] retry_cnt,
  output logic [MW-1:0] cur_mode
);
  localparam int CA = (RST_HOLD_CYC > LOCK_WAIT_CYC) ? RST_HOLD_CYC : LOCK_WAIT_CYC;
  localparam int CB = (LOCK_STABLE_CYC > DS_CYC) ? LOCK_STABLE_CYC : DS_CYC;
  localparam int CW = $clog2(((CA > CB) ? CA : CB) + 1);
  localparam logic [CW-1:0] RST_END = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(LOCK_WAIT_CYC - 1);
  localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] DS_END = CW'(DS_CYC - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [MW:0] NM = (MW + 1)'(NUM_MODES);
  typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_SERDES_RST, S_READY, S_FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry_n, retry_inc;
  logic [MW-1:0] mode_n;
  logic [17:0] sel_n;
  logic [1:0] sync;
  logic lock_s, fail, valid, ack_n, err_n, relock_n;
  assign lock_s = sync[1];
  assign valid = {1'b0, mode_sel} < NM;
  assign retry_inc = (retry_cnt == RMAX) ? retry_cnt : retry_cnt + 1'b1;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    retry_n = retry_cnt;
    mode_n = cur_mode;
    sel_n = {idsel, fbdsel, odsel};
    ack_n = 1'b0;
    err_n = 1'b0;
    relock_n = 1'b0;
    fail = 1'b0;
    case (state)
      S_PLL_RST: if (cnt == RST_END) begin
        state_n = S_WAIT_LOCK;
        cnt_n = '0;
      end
      S_WAIT_LOCK: if (lock_s) begin
        state_n = S_STABLE;
        cnt_n = '0;
      end else fail = (cnt == WAIT_END);
      S_STABLE: if (!lock_s) fail = 1'b1;
      else if (cnt == STB_END) begin
        state_n = S_SERDES_RST;
        cnt_n = '0;
      end
      S_SERDES_RST: if (cnt == DS_END) begin
        state_n = S_READY;
        cnt_n = '0;
        retry_n = '0;
      end
      S_READY: begin
        cnt_n = cnt;
        if (!lock_s) begin
          relock_n = 1'b1;
          retry_n = '0;
          state_n = S_PLL_RST;
          cnt_n = '0;
        end
      end
      default: cnt_n = cnt;
    endcase
    if (fail) begin
      retry_n = retry_inc;
      state_n = (retry_inc == RMAX) ? S_FAULT : S_PLL_RST;
      cnt_n = '0;
    end
    // an accepted request overrides any lock event decided in the same cycle
    if (mode_req && valid) begin
      mode_n = mode_sel;
      sel_n = MODE_TABLE[int'(mode_sel)*18 +: 18];
      retry_n = '0;
      state_n = S_PLL_RST;
      cnt_n = '0;
      ack_n = 1'b1;
      relock_n = 1'b0;
    end
    err_n = mode_req && !valid;
  end
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      state <= S_PLL_RST;
      cnt <= '0;
      retry_cnt <= '0;
      cur_mode <= '0;
      {idsel, fbdsel, odsel} <= MODE_TABLE[17:0];
      mode_ack <= 1'b0;
      mode_err <= 1'b0;
      relock_evt <= 1'b0;
      pll_reset <= 1'b1;
      serdes_rst <= 1'b1;
      pll_ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      sync <= {sync[0], pll_lock};
      state <= state_n;
      cnt <= cnt_n;
      retry_cnt <= retry_n;
      cur_mode <= mode_n;
      {idsel, fbdsel, odsel} <= sel_n;
      mode_ack <= ack_n;
      mode_err <= err_n;
      relock_evt <= relock_n;
      pll_reset <= (state_n == S_PLL_RST) || (state_n == S_FAULT);
      serdes_rst <= state_n != S_READY;
      pll_ready <= state_n == S_READY;
      fault <= state_n == S_FAULT;
    end
  end
endmodule

// File: tb/tb_lvds_tx_pll_seq.sv
// tb_lvds_tx_pll_seq: directed bench for the rPLL sequencer with hand-computed cycle timings.
module tb_lvds_tx_pll_seq;
  localparam logic [17:0] E0 = {6'd1, 6'd2, 6'd3};
  localparam logic [17:0] E1 = {6'd4, 6'd5, 6'd6};
  localparam logic [17:0] E2 = {6'd7, 6'd8, 6'd9};
  logic clkin = 1'b0;
  logic reset_n, mode_req, mode_ack, mode_err, pll_lock, pll_reset;
  logic serdes_rst, pll_ready, fault, relock_evt;
  logic [1:0] mode_sel, cur_mode, retry_cnt;
  logic [5:0] idsel, fbdsel, odsel;
  int checks = 0, errors = 0;
  int n, run, pulses;
  lvds_tx_pll_seq #(
    .NUM_MODES(3), .MODE_TABLE({E2, E1, E0}), .RST_HOLD_CYC(4), .LOCK_WAIT_CYC(32),
    .LOCK_STABLE_CYC(8), .DS_CYC(4), .MAX_RETRY(2)
  ) dut (
    .clkin(clkin), .reset_n(reset_n), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_ack(mode_ack), .mode_err(mode_err), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .serdes_rst(serdes_rst),
    .pll_ready(pll_ready), .fault(fault), .relock_evt(relock_evt),
    .retry_cnt(retry_cnt), .cur_mode(cur_mode)
  );
  always #5 clkin = ~clkin;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clkin);
    #1;
  endtask
  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && !pll_ready; i++) tick;
    check(tag, pll_ready, 1);
  endtask
  task automatic pulse_len(output int len);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pll_reset) break;
      len++;
      tick;
    end
  endtask
  initial begin
    reset_n = 1'b0;
    pll_lock = 1'b0;
    mode_req = 1'b0;
    mode_sel = '0;
    repeat (2) tick;
    check("rst_pll_reset", pll_reset, 1);
    check("rst_serdes", serdes_rst, 1);
    check("rst_ready", pll_ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_mode", cur_mode, 0);
    check("rst_sel", {idsel, fbdsel, odsel}, E0);
    check("rst_pulses", {mode_ack, mode_err, relock_evt}, 0);
    reset_n = 1'b1;
    repeat (3) tick;
    check("bu_hold", pll_reset, 1);
    tick;
    check("bu_hold_end", pll_reset, 0);
    repeat (6) tick;
    pll_lock = 1'b1;
    repeat (14) tick;
    check("bu_ready_early", pll_ready, 0);
    check("bu_serdes_early", serdes_rst, 1);
    tick;
    check("bu_ready", pll_ready, 1);
    check("bu_serdes", serdes_rst, 0);
    check("bu_retry", retry_cnt, 0);
    pll_lock = 1'b0;
    repeat (2) tick;
    check("loss_ready_hold", {pll_ready, relock_evt}, 2'b10);
    tick;
    check("loss_relock", relock_evt, 1);
    check("loss_ready", pll_ready, 0);
    check("loss_pll_reset", pll_reset, 1);
    pll_lock = 1'b1;
    n = 0;
    repeat (5) begin
      tick;
      n += int'(relock_evt);
    end
    check("loss_single_pulse", n, 0);
    wait_ready("loss_requal");
    check("loss_retry", retry_cnt, 0);
    mode_sel = 2'd0;
    mode_req = 1'b1;
    tick;
    mode_req = 1'b0;
    check("same_mode_ack", mode_ack, 1);
    check("same_mode_reset", {pll_reset, pll_ready}, 2'b10);
    tick;
    check("same_mode_ack_end", mode_ack, 0);
    repeat (8) tick;
    pll_lock = 1'b0;
    repeat (3) tick;
    pll_lock = 1'b1;
    check("glitch_retry", retry_cnt, 1);
    pulse_len(n);
    check("glitch_rst_len", n, 4);
    wait_ready("glitch_ready");
    check("glitch_retry_clr", retry_cnt, 0);
    mode_sel = 2'd2;
    mode_req = 1'b1;
    tick;
    mode_req = 1'b0;
    check("sw_ack", mode_ack, 1);
    check("sw_mode", cur_mode, 2);
    check("sw_sel", {idsel, fbdsel, odsel}, E2);
    check("sw_reset", {pll_reset, pll_ready}, 2'b10);
    tick;
    check("sw_ack_end", mode_ack, 0);
    pulse_len(n);
    check("sw_rst_len", n + 1, 4);
    wait_ready("sw_ready");
    mode_sel = 2'd3;
    mode_req = 1'b1;
    tick;
    mode_req = 1'b0;
    check("bad_err", mode_err, 1);
    check("bad_ack", mode_ack, 0);
    check("bad_mode", cur_mode, 2);
    check("bad_sel", {idsel, fbdsel, odsel}, E2);
    check("bad_state", {pll_ready, pll_reset}, 2'b10);
    tick;
    check("bad_err_end", mode_err, 0);
    pll_lock = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_from_ready", {pll_reset, pll_ready, serdes_rst}, 3'b101);
    tick;
    reset_n = 1'b1;
    run = 1;
    pulses = 0;
    for (int i = 0; i < 300 && !fault; i++) begin
      tick;
      if (pll_reset && !fault) run++;
      else if (!pll_reset) begin
        if (run > 0) begin
          pulses++;
          check("nl_rst_len", run, 4);
        end
        run = 0;
      end
    end
    check("nl_fault", fault, 1);
    check("nl_pulses", pulses, 2);
    check("nl_retry", retry_cnt, 2);
    check("nl_outs", {pll_reset, serdes_rst, pll_ready}, 3'b110);
    repeat (5) tick;
    check("nl_fault_hold", {fault, pll_reset}, 2'b11);
    mode_sel = 2'd1;
    mode_req = 1'b1;
    tick;
    mode_req = 1'b0;
    check("fx_fault", fault, 0);
    check("fx_ack", mode_ack, 1);
    check("fx_mode", cur_mode, 1);
    check("fx_retry", retry_cnt, 0);
    check("fx_sel", {idsel, fbdsel, odsel}, E1);
    check("fx_reset", pll_reset, 1);
    repeat (4) tick;
    check("fx_wait_lock", pll_reset, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_pll_reset", pll_reset, 1);
    check("ar_mode", cur_mode, 0);
    check("ar_sel", {idsel, fbdsel, odsel}, E0);
    tick;
    reset_n = 1'b1;
    pll_lock = 1'b1;
    wait_ready("ar_ready");
    check("ar_mode_final", cur_mode, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
